jt89_mix_seq: RTL and testbench
===============================

// Module: jt89_mix_seq
// PURPOSE
//   Sequencer for the jt89 output mixer (CIC comb/interpolator/integrator path).
//   - Derives the mixer's per-sample strobe cen_16 from the chip clk_en.
//   - Owns the mixer reset (mix_rst).
//   - Applies a host-written channel mute mask only on sample boundaries.
//   - Runs flush/drain sequences on enable/disable so the integrators start
//     from zero and do not click.
// PARAMETERS
//   DIV        16  clk_en pulses per cen_16 sample (interpolation ratio); must be >=2
//   FLUSH_LEN   4  samples (cen_16 ticks) spent in FLUSH and in DRAIN; must be >=1
// PORTS
//   clk      in   1  system clock
//   rst      in   1  synchronous reset, active high
//   clk_en   in   1  chip clock enable, one clk wide
//   cfg_we   in   1  config write strobe, one clk wide
//   cfg_din  in   8  [7]=enable, [3:0]=channel enables {noise,ch2,ch1,ch0}; [6:4] ignored
//   cen_16   out  1  sample strobe to mixer; coincident with every DIV-th clk_en
//   mix_rst  out  1  reset to mixer integrators
//   ch_en    out  4  per-channel gate to mixer inputs (1 = pass, 0 = force 9'd0)
//   busy     out  1  high in FLUSH or DRAIN
// BEHAVIOUR
//   Reset (rst=1, sampled on clk), all registered:
//     phase=0, cen_16=0, mix_rst=1, ch_en=4'b0, busy=0, state=OFF,
//     pend_en=0, pend_mask=0, cnt=0.
//   Phase counter:
//     - phase increments on each clk_en and wraps DIV-1 -> 0.
//     - cen_16 = clk_en & (phase==DIV-1), combinational from registered phase.
//     - The counter runs in every state, so cen_16 keeps ticking in OFF.
//     - First cen_16 after reset is on the DIV-th clk_en.
//     - clk_en held high continuously gives cen_16 every DIV clk.
//   Config writes:
//     - cfg_we=1 loads pend_en and pend_mask on the same edge; writes are always accepted.
//     - Later writes overwrite earlier ones; only the last value before a tick counts.
//     - All state and ch_en updates happen only on a tick (cen_16=1 clk edge).
//     - cfg_we on the same edge as a tick: the tick uses the old pend_* values;
//       the new value acts at the next tick.
//   FSM. Evaluated only on ticks; cnt counts ticks spent in FLUSH/DRAIN.
//     OFF:   mix_rst=1, ch_en=0, busy=0.
//            pend_en=1 -> FLUSH, cnt=0, mix_rst<=0.
//     FLUSH: mix_rst=0, ch_en=0, busy=1. Lets comb history fill with zeros.
//            pend_en=0 -> DRAIN, cnt=0.
//            else cnt==FLUSH_LEN-1 -> RUN, ch_en<=pend_mask.
//            else cnt++.
//     RUN:   mix_rst=0, busy=0.
//            pend_en=1: ch_en<=pend_mask on every tick (mask change = one-tick latency).
//            pend_en=0 -> DRAIN, cnt=0, ch_en<=0.
//     DRAIN: mix_rst=0, ch_en=0, busy=1.
//            cnt==FLUSH_LEN-1 -> OFF, mix_rst<=1.
//            else cnt++.
//            pend_en is ignored during DRAIN; re-enable waits for OFF, then
//            FLUSH at the next tick.
//   Latency:
//     - enable write to first ch_en!=0: FLUSH_LEN+1 ticks, counting the first
//       tick after the write.
//     - disable write to mix_rst=1: FLUSH_LEN+1 ticks.
//   Mid-operation rst: returns to the reset values on the next clk regardless
//     of state; no drain is performed.
//   cnt width: clog2(FLUSH_LEN) bits, minimum 1.
//   Never in the same cycle: mix_rst=1 together with ch_en!=0.
// TESTING
//   1. Phase: DIV=16, clk_en every 3rd clk, 64 clk_en
//      -> cen_16 exactly 4 times, on clk_en #16/#32/#48/#64, each 1 clk wide.
//   2. Enable: write 8'h8F, FLUSH_LEN=4
//      -> busy=1 and mix_rst=0 at tick 1; ch_en=4'hF at tick 5; busy=0 at tick 5.
//   3. Mask: in RUN write 8'h85 between ticks -> ch_en=4'h5 at next tick.
//      Write on the tick edge itself -> ch_en unchanged until the following tick.
//   4. Disable: in RUN write 8'h0F
//      -> ch_en=0 at tick 1; busy 1 for ticks 1..4; mix_rst=1 at tick 5, state OFF.
//   5. Toggle: enable, then disable during FLUSH at its 2nd tick -> DRAIN, ch_en stays 0.
//      Re-enable during DRAIN -> OFF, then FLUSH at the next tick.
//   6. Reset in RUN with ch_en=4'hF: assert rst 1 clk
//      -> next clk mix_rst=1, ch_en=0, busy=0; next cen_16 only after 16 further clk_en.

Source files
------------

// File: rtl/jt89_mix_seq.sv
// jt89 mixer sequencer: derives the per-sample strobe for the CIC mixer,
// owns the mixer reset, applies the host channel mask on sample boundaries
// and runs flush/drain sequences so the integrators never click.
module jt89_mix_seq #(
    parameter int DIV       = 16,
    parameter int FLUSH_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cfg_we,
    input  logic [7:0] cfg_din,
    output logic       cen_16,
    output logic       mix_rst,
    output logic [3:0] ch_en,
    output logic       busy
);

    localparam int PHASE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W   = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_FLUSH,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PHASE_W-1:0] phase;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               mix_rst_nxt;
    logic               busy_nxt;
    logic [3:0]         ch_en_nxt;
    logic               pend_en;
    logic [3:0]         pend_mask;

    // The sample strobe is the last clk_en of each DIV-long phase cycle.
    assign cen_16 = clk_en & (phase == PHASE_LAST);

    // Phase counter free-runs on clk_en in every state so samples keep flowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (clk_en) begin
            if (phase == PHASE_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PHASE_W'(1);
            end
        end
    end

    // Host writes are always accepted; only the latest value is seen by the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_en   <= 1'b0;
            pend_mask <= 4'b0;
        end else if (cfg_we) begin
            pend_en   <= cfg_din[7];
            pend_mask <= cfg_din[3:0];
        end
    end

    // State and mixer-facing outputs only move on sample boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_OFF;
            cnt     <= '0;
            mix_rst <= 1'b1;
            ch_en   <= 4'b0;
            busy    <= 1'b0;
        end else if (cen_16) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mix_rst <= mix_rst_nxt;
            ch_en   <= ch_en_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state logic: flush fills comb history with zeros before channels open,
    // drain lets the integrators settle before the mixer is held in reset.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mix_rst_nxt = mix_rst;
        ch_en_nxt   = ch_en;
        busy_nxt    = busy;
        case (state)
            ST_OFF: begin
                mix_rst_nxt = 1'b1;
                ch_en_nxt   = 4'b0;
                busy_nxt    = 1'b0;
                if (pend_en) begin
                    state_nxt   = ST_FLUSH;
                    cnt_nxt     = '0;
                    mix_rst_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            ST_FLUSH: begin
                mix_rst_nxt = 1'b0;
                ch_en_nxt   = 4'b0;
                busy_nxt    = 1'b1;
                if (!pend_en) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                    ch_en_nxt = pend_mask;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                mix_rst_nxt = 1'b0;
                busy_nxt    = 1'b0;
                if (pend_en) begin
                    ch_en_nxt = pend_mask;
                end else begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                    ch_en_nxt = 4'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_DRAIN: begin
                mix_rst_nxt = 1'b0;
                ch_en_nxt   = 4'b0;
                busy_nxt    = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt   = ST_OFF;
                    mix_rst_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt   = ST_OFF;
                cnt_nxt     = '0;
                mix_rst_nxt = 1'b1;
                ch_en_nxt   = 4'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jt89_mix_seq.sv
// Testbench for jt89_mix_seq: a mode/ticks-left model of the sequencer is
// compared against the DUT every cycle, plus hand-computed directed checks.
module tb_jt89_mix_seq;

    localparam int DIV       = 16;
    localparam int FLUSH_LEN = 4;

    localparam int M_OFF   = 0;
    localparam int M_FLUSH = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       clk_en  = 1'b0;
    logic       cfg_we  = 1'b0;
    logic [7:0] cfg_din = 8'h00;
    logic       cen_16;
    logic       mix_rst;
    logic [3:0] ch_en;
    logic       busy;

    int checks     = 0;
    int failures   = 0;
    int ce_period  = 3;
    bit check_en   = 1'b0;

    // model state
    int       m_mode     = M_OFF;
    int       m_left     = 0;
    int       m_ce_count = 0;
    logic [3:0] m_ch        = 4'b0;
    logic       m_pend_en   = 1'b0;
    logic [3:0] m_pend_mask = 4'b0;

    jt89_mix_seq #(.DIV(DIV), .FLUSH_LEN(FLUSH_LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .cfg_we  (cfg_we),
        .cfg_din (cfg_din),
        .cen_16  (cen_16),
        .mix_rst (mix_rst),
        .ch_en   (ch_en),
        .busy    (busy)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // clk_en generator: one clk-wide pulse every ce_period clocks
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            clk_en = ((n % ce_period) == 0);
            n++;
        end
    end

    // Behavioural model: a tick is every DIV-th clk_en since reset; sequencing
    // is expressed as a mode plus the number of ticks left in that mode.
    always @(posedge clk) begin
        if (rst) begin
            m_mode      = M_OFF;
            m_left      = 0;
            m_ce_count  = 0;
            m_ch        = 4'b0;
            m_pend_en   = 1'b0;
            m_pend_mask = 4'b0;
        end else begin
            if (clk_en && ((m_ce_count % DIV) == DIV - 1)) begin
                case (m_mode)
                    M_OFF: begin
                        if (m_pend_en) begin
                            m_mode = M_FLUSH;
                            m_left = FLUSH_LEN;
                        end
                    end
                    M_FLUSH: begin
                        if (!m_pend_en) begin
                            m_mode = M_DRAIN;
                            m_left = FLUSH_LEN;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin
                                m_mode = M_RUN;
                                m_ch   = m_pend_mask;
                            end
                        end
                    end
                    M_RUN: begin
                        if (m_pend_en) begin
                            m_ch = m_pend_mask;
                        end else begin
                            m_mode = M_DRAIN;
                            m_left = FLUSH_LEN;
                            m_ch   = 4'b0;
                        end
                    end
                    default: begin
                        m_left--;
                        if (m_left == 0) m_mode = M_OFF;
                    end
                endcase
            end
            if (cfg_we) begin
                m_pend_en   = cfg_din[7];
                m_pend_mask = cfg_din[3:0];
            end
            if (clk_en) m_ce_count++;
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (check_en) begin
            check_output("cen_16", cen_16, clk_en && ((m_ce_count % DIV) == DIV - 1));
            check_output("mix_rst", mix_rst, m_mode == M_OFF);
            check_output("busy", busy, (m_mode == M_FLUSH) || (m_mode == M_DRAIN));
            check_output("ch_en", ch_en, m_ch);
            check_output("rst_with_ch", mix_rst && (ch_en != 4'b0), 0);
        end
    end

    // Wait for the next DUT tick; returns on the negedge after the tick edge
    task automatic wait_tick();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (cen_16 === 1'b1) break;
            n++;
            if (n > 200) begin
                check_output("tick_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) wait_tick();
    endtask

    // Config write landing on a non-tick edge
    task automatic apply_stimulus(input logic [7:0] din);
        @(posedge clk);
        #1;
        cfg_we  = 1'b1;
        cfg_din = din;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
    endtask

    // Config write landing exactly on a tick edge
    task automatic write_on_tick(input logic [7:0] din);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (cen_16 === 1'b1) break;
            n++;
            if (n > 200) begin
                check_output("tick_edge_timeout", 0, 1);
                break;
            end
        end
        cfg_we  = 1'b1;
        cfg_din = din;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ce_idx;
        int pulses;
        int pos [4];
        int n;
        bit seen;

        // reset and phase test with clk_en every 3rd clk
        repeat (4) @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        check_output("reset_mix_rst", mix_rst, 1);
        check_output("reset_ch_en", ch_en, 0);
        check_output("reset_busy", busy, 0);
        ce_idx = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) pos[i] = 0;
        for (int i = 0; i < 400 && ce_idx < 64; i++) begin
            if (clk_en) ce_idx++;
            if (cen_16) begin
                if (!clk_en) check_output("cen_without_clk_en", 1, 0);
                if (pulses < 4) pos[pulses] = ce_idx;
                pulses++;
            end
            if (ce_idx < 64) @(negedge clk);
        end
        check_output("phase_ce_seen", ce_idx, 64);
        check_output("phase_pulses", pulses, 4);
        check_output("phase_pos0", pos[0], 16);
        check_output("phase_pos1", pos[1], 32);
        check_output("phase_pos2", pos[2], 48);
        check_output("phase_pos3", pos[3], 64);

        // continuous clk_en from here on
        ce_period = 1;
        wait_tick();

        // enable
        apply_stimulus(8'h8F);
        wait_tick();
        check_output("en_t1_busy", busy, 1);
        check_output("en_t1_mix_rst", mix_rst, 0);
        wait_ticks(3);
        check_output("en_t4_ch_en", ch_en, 4'h0);
        check_output("en_t4_busy", busy, 1);
        wait_tick();
        check_output("en_t5_ch_en", ch_en, 4'hF);
        check_output("en_t5_busy", busy, 0);

        // mask change between ticks and on a tick edge
        apply_stimulus(8'h85);
        wait_tick();
        check_output("mask_next_tick", ch_en, 4'h5);
        write_on_tick(8'h8A);
        @(negedge clk);
        check_output("mask_on_edge_held", ch_en, 4'h5);
        wait_tick();
        check_output("mask_on_edge_next", ch_en, 4'hA);

        // disable
        apply_stimulus(8'h0F);
        wait_tick();
        check_output("dis_t1_ch_en", ch_en, 4'h0);
        check_output("dis_t1_busy", busy, 1);
        check_output("dis_t1_mix_rst", mix_rst, 0);
        wait_ticks(3);
        check_output("dis_t4_busy", busy, 1);
        check_output("dis_t4_mix_rst", mix_rst, 0);
        wait_tick();
        check_output("dis_t5_mix_rst", mix_rst, 1);
        check_output("dis_t5_busy", busy, 0);

        // toggle: disable during flush, re-enable during drain
        apply_stimulus(8'h8F);
        wait_tick();
        check_output("tog_flush_busy", busy, 1);
        apply_stimulus(8'h0F);
        wait_tick();
        check_output("tog_drain_busy", busy, 1);
        check_output("tog_drain_ch_en", ch_en, 4'h0);
        apply_stimulus(8'h8F);
        wait_ticks(3);
        check_output("tog_drain_still_busy", busy, 1);
        check_output("tog_drain_mix_rst", mix_rst, 0);
        wait_tick();
        check_output("tog_off_mix_rst", mix_rst, 1);
        check_output("tog_off_busy", busy, 0);
        wait_tick();
        check_output("tog_reflush_busy", busy, 1);
        check_output("tog_reflush_mix_rst", mix_rst, 0);
        wait_ticks(4);
        check_output("tog_run_ch_en", ch_en, 4'hF);

        // reset while running
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_run_mix_rst", mix_rst, 1);
        check_output("rst_run_ch_en", ch_en, 4'h0);
        check_output("rst_run_busy", busy, 0);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (clk_en) n++;
            if (cen_16) seen = 1'b1;
            else @(negedge clk);
        end
        check_output("rst_tick_seen", seen, 1);
        check_output("rst_clk_en_count", n, 16);

        repeat (4) @(negedge clk);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
